// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops plus iterative MULTU and (optional) DIVU.
// Latency: single-cycle/illegal/divide-by-zero results valid after the accept edge; MULTU/DIVU after WIDTH further edges.
// Backpressure: result held in DONE until out_ready; in_ready low while iterating or while a result is held unconsumed.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (alu_op, alu_in1, alu_in2)
//   out_valid / out_ready result handshake (alu_out, alu_hi, alu_zero, alu_ovf, alu_err)
// Build option: define ALU_SEQ_DIV_EN to build the restoring divider; otherwise DIVU is an illegal opcode.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_in1,
    input  logic [WIDTH-1:0] alu_in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_hi,
    output logic             alu_zero,
    output logic             alu_ovf,
    output logic             alu_err
);

    localparam int H     = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_LUI   = 4'd3;
    localparam logic [3:0] OP_ADDIU = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_MULTU = 4'd6;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIVU  = 4'd7;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_out;
    logic [WIDTH-1:0]     r_hi;
    logic                 r_ovf;
    logic                 r_err;
    // Multiplicand or divisor for the iterative ops.
    logic [WIDTH-1:0]     r_opb;
    // Iteration register: MULTU {partial product, remaining multiplier},
    // DIVU {partial remainder, dividend shifting into quotient}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_uimm;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic [WIDTH-1:0]     w_sc_out;
    logic                 w_sc_ovf;
    logic                 w_sc_err;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]       w_div_trial;
    logic [2*WIDTH-1:0]   w_div_nxt;
`endif

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == S_DONE);
    assign alu_out   = r_out;
    assign alu_hi    = r_hi;
    assign alu_ovf   = r_ovf;
    assign alu_err   = r_err;
    // Qualified by DONE so the flag reads 0 out of reset and between results.
    assign alu_zero  = (r_state == S_DONE) && (r_out == '0);

    // Single-cycle datapath; sign-extended to WIDTH+1 bits so the top two
    // bits expose signed overflow.
    assign w_uimm = {{(WIDTH - H){1'b0}}, alu_in2[H-1:0]};
    assign w_add  = {alu_in1[WIDTH-1], alu_in1} + {alu_in2[WIDTH-1], alu_in2};
    assign w_sub  = {alu_in1[WIDTH-1], alu_in1} - {alu_in2[WIDTH-1], alu_in2};

    always_comb begin
        w_sc_out = '0;
        w_sc_ovf = 1'b0;
        w_sc_err = 1'b0;
        case (alu_op)
            OP_ADD: begin
                w_sc_out = w_add[WIDTH-1:0];
                w_sc_ovf = w_add[WIDTH] ^ w_add[WIDTH-1];
            end
            OP_SUB: begin
                w_sc_out = w_sub[WIDTH-1:0];
                w_sc_ovf = w_sub[WIDTH] ^ w_sub[WIDTH-1];
            end
            OP_OR:    w_sc_out = alu_in1 | w_uimm;
            OP_LUI:   w_sc_out = {alu_in2[H-1:0], {(WIDTH - H){1'b0}}};
            OP_ADDIU: w_sc_out = w_add[WIDTH-1:0];
            OP_NOR:   w_sc_out = ~(alu_in1 | w_uimm);
            // Iterative ops never take this result path.
            OP_MULTU: w_sc_out = '0;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU:  w_sc_out = '0;
`endif
            default:  w_sc_err = 1'b1;
        endcase
    end

    // Shift-add step: add the multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole register right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and try
    // the subtract; a borrow (top bit set) means restore and shift in a 0.
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_nxt   = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_hi    <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_out   <= w_mul_nxt[WIDTH-1:0];
                        r_hi    <= w_mul_nxt[2*WIDTH-1:WIDTH];
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_out   <= w_div_nxt[WIDTH-1:0];
                        r_hi    <= w_div_nxt[2*WIDTH-1:WIDTH];
                        r_ovf   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
`endif
                default: ;
            endcase

            // Accepts only happen in IDLE or DONE, so this never collides
            // with the iteration updates above.
            if (w_accept) begin
                case (alu_op)
                    OP_MULTU: begin
                        r_opb   <= alu_in1;
                        r_acc   <= {{WIDTH{1'b0}}, alu_in2};
                        r_cnt   <= '0;
                        r_state <= S_MUL;
                    end
`ifdef ALU_SEQ_DIV_EN
                    OP_DIVU: begin
                        if (alu_in2 == '0) begin
                            r_out   <= '1;
                            r_hi    <= alu_in1;
                            r_ovf   <= 1'b0;
                            r_err   <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_opb   <= alu_in2;
                            r_acc   <= {{WIDTH{1'b0}}, alu_in1};
                            r_cnt   <= '0;
                            r_state <= S_DIV;
                        end
                    end
`endif
                    default: begin
                        r_out   <= w_sc_out;
                        r_hi    <= '0;
                        r_ovf   <= w_sc_ovf;
                        r_err   <= w_sc_err;
                        r_state <= S_DONE;
                    end
                endcase
            end else if ((r_state == S_DONE) && out_ready) begin
                r_state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed vectors, expected responses queued
// by the driver and checked by an independent output monitor.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic [31:0] alu_hi;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int first_seen = -1;

    typedef struct {
        string       name;
        logic [31:0] out;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic        err;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .alu_hi    (alu_hi),
        .alu_zero  (alu_zero),
        .alu_ovf   (alu_ovf),
        .alu_err   (alu_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Offer one operation; lat = edges after the accept edge until out_valid.
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic [31:0] eh,
                         input logic ez, input logic eov, input logic eer, input int lat);
        exp_t e;
        int   n;
        in_valid = 1'b1;
        alu_op   = op;
        alu_in1  = a;
        alu_in2  = b;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk({nm, "_accept_timeout"}, 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.name    = nm;
        e.out     = eo;
        e.hi      = eh;
        e.zero    = ez;
        e.ovf     = eov;
        e.err     = eer;
        e.exp_cyc = cyc + lat;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    // Monitor: checks held results against the queue head, and pops on transfer.
    always @(negedge clk) begin
        if (rst) begin
            first_seen = -1;
        end else begin
            if (out_valid && first_seen < 0) first_seen = cyc;
            if (out_valid && !out_ready && sb.size() > 0)
                chk({sb[0].name, "_held"}, {alu_out, alu_hi, alu_zero, alu_ovf, alu_err},
                    {sb[0].out, sb[0].hi, sb[0].zero, sb[0].ovf, sb[0].err});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 128'(out_valid), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_result"}, {alu_out, alu_hi, alu_zero, alu_ovf, alu_err},
                        {e.out, e.hi, e.zero, e.ovf, e.err});
                    chk({e.name, "_latency"}, 128'(first_seen), 128'(e.exp_cyc));
                end
                first_seen = -1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 4'd0;
        alu_in1   = '0;
        alu_in2   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_outputs", {alu_out, alu_hi, alu_zero, alu_ovf, alu_err}, 128'(0));
        rst = 1'b0;

        // Single-cycle ops, back to back with out_ready high.
        issue("add_ovf",  4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1, 0, 0);
        issue("sub_zero", 4'd1, 32'd5,        32'd5,        32'h00000000, 0, 1, 0, 0, 0);
        issue("lui",      4'd3, 32'h0,        32'h00001234, 32'h12340000, 0, 0, 0, 0, 0);
        issue("nor",      4'd5, 32'h0,        32'hFFFF00F0, 32'hFFFFFF0F, 0, 0, 0, 0, 0);
        issue("or",       4'd2, 32'h12340000, 32'hABCD00FF, 32'h123400FF, 0, 0, 0, 0, 0);
        issue("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 0, 1, 0, 0);
        issue("addiu",    4'd4, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 0, 0, 0);

        // MULTU; offer a junk op during the iteration, which must be ignored.
        issue("mul_max", 4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 32);
        in_valid = 1'b1;
        alu_op   = 4'd0;
        alu_in1  = 32'h11111111;
        alu_in2  = 32'h22222222;
        bad = 0;
        repeat (31) begin
            @(negedge clk);
            if (in_ready || out_valid) bad++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mul_in_ready_low", 128'(bad), 128'(0));
        issue("mul_hi_only", 4'd6, 32'h00010000, 32'h00030000, 32'h00000000, 32'h00000003, 1, 0, 0, 32);
        issue("mul_small",   4'd6, 32'd1000,     32'd3,        32'd3000,     32'h0,        0, 0, 0, 32);

        issue("illegal9", 4'd9, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1, 0, 1, 0);
`ifdef ALU_SEQ_DIV_EN
        issue("div_100_7", 4'd7, 32'd100,      32'd7, 32'd14,       32'd2,        0, 0, 0, 32);
        issue("div_zero",  4'd7, 32'hDEADBEEF, 32'd0, 32'hFFFFFFFF, 32'hDEADBEEF, 0, 0, 0, 0);
`else
        issue("div_off",      4'd7, 32'd100,      32'd7, 32'h0, 32'h0, 1, 0, 1, 0);
        issue("div_zero_off", 4'd7, 32'hDEADBEEF, 32'd0, 32'h0, 32'h0, 1, 0, 1, 0);
`endif

        // Back-pressure: hold an ADD result, then release with a new OR.
        issue("bp_add", 4'd0, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready || !out_valid) bad++;
        end
        chk("bp_in_ready_low", 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("bp_or", 4'd2, 32'h0000F0F0, 32'hFFFF0F0F, 32'h0000FFFF, 0, 0, 0, 0, 0);

        // Reset in the middle of a multiply.
        issue("mul_aborted", 4'd6, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0, 32);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_outputs", {alu_out, alu_hi, alu_zero, alu_ovf, alu_err}, 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        sb.delete();
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("midrst_no_valid", 128'(bad), 128'(0));

        issue("post_rst_sub", 4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 0, 0, 0, 0, 0);

        bad = 0;
        while (sb.size() > 0 && bad < 100) begin
            @(negedge clk);
            bad++;
        end
        chk("drain_pending", 128'(sb.size()), 128'(0));
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. Executes the existing single-cycle operations (ADD, SUB, OR, LUI, ADDIU, NOR) with a registered result, plus iterative unsigned multiply and divide that take multiple cycles. It sits between the ID/EX operand latch and the EX/MEM stage. The valid/ready handshake lets the pipeline stall while a long operation runs.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- alu_op  in  4  opcode: 0 ADD, 1 SUB, 2 OR, 3 LUI, 4 ADDIU, 5 NOR, 6 MULTU, 7 DIVU; 8–15 illegal.
- alu_in1  in  WIDTH  operand A (rs).
- alu_in2  in  WIDTH  operand B (rt or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- alu_out  out  WIDTH  result, or LO for MULTU/DIVU.
- alu_hi  out  WIDTH  HI for MULTU/DIVU; 0 for all other ops.
- alu_zero  out  1  alu_out == 0.
- alu_ovf  out  1  signed overflow; ADD/SUB only.
- alu_err  out  1  illegal opcode, or DIVU compiled out.

## Operation
- States:
  - IDLE.
  - MUL: iterative multiply.
  - DIV: iterative divide.
  - DONE: result held.
- Transfer rule:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- Single-cycle ops: the result is computed and registered on the accept edge; the next state is DONE.
- Arithmetic rules:
  - H = WIDTH/2.
  - uimm = zero-extend of alu_in2[H-1:0].
  - ADD/SUB: alu_in1 ± alu_in2 computed on WIDTH+1 bits with sign extension. alu_ovf = bit WIDTH xor bit WIDTH-1.
  - ADDIU: alu_in1 + alu_in2, modulo 2^WIDTH; alu_ovf = 0.
  - OR: alu_in1 | uimm.
  - NOR: ~(alu_in1 | uimm).
  - LUI: {alu_in2[H-1:0], H zeros}.
- MULTU:
  - The accept edge loads the multiplicand, the multiplier and a 2·WIDTH accumulator, and clears a log2(WIDTH)+1-bit counter.
  - One shift-add step per edge for WIDTH edges, then DONE.
  - {alu_hi, alu_out} = full unsigned product.
- DIVU:
  - Restoring division, one quotient bit per edge for WIDTH edges, then DONE.
  - alu_out = quotient, alu_hi = remainder.
  - Divisor 0: no iteration; go straight to DONE with alu_out = all ones and alu_hi = alu_in1.
- Illegal opcode: single-cycle path, results 0, alu_err = 1.
- DONE:
  - out_valid = 1; all result outputs are held stable until out_ready.
  - out_ready without a new accept: go to IDLE.
  - out_ready with a simultaneous accept: load the new operation, with the same next-state rules as from IDLE.
- in_valid during MUL/DIV is ignored (in_ready = 0); operands are captured only on the accept edge.
- Reset, including mid-MUL/DIV:
  - The operation is aborted and state goes to IDLE.
  - out_valid, alu_out, alu_hi, alu_zero, alu_ovf and alu_err are all 0.
  - in_ready = 1 after the reset edge.

## Timing
- Latency is counted from the accepting edge k:
  - Single-cycle and illegal ops: out_valid after edge k.
  - DIVU by zero: out_valid after edge k.
  - MULTU/DIVU: out_valid after edge k+WIDTH.
- Throughput:
  - Single-cycle ops: one per cycle while out_ready = 1.
  - MULTU/DIVU: one per WIDTH+1 cycles.
- in_ready is combinational from state and out_ready. There is no combinational path from in_valid to any output.
- alu_zero is derived from the registered alu_out.

## Configuration
- ALU_SEQ_DIV_EN defined: DIV state and restoring divider are built as described.
- ALU_SEQ_DIV_EN undefined:
  - No divider hardware; DIVU is treated as an illegal opcode.
  - Result: single-cycle, out_valid after edge k, alu_out = alu_hi = 0, alu_err = 1.
  - All other ops are unchanged.

## Test plan
All scenarios use WIDTH=32.
- Reset: assert rst during MUL iteration 10 → after the edge, out_valid = 0, alu_out = 0 and in_ready = 1. Holding out_ready = 1 for a further 40 cycles produces no out_valid.
- Single-cycle ops: ADD 0x7FFFFFFF + 1 → alu_out = 0x80000000, alu_ovf = 1, out_valid after 1 edge. SUB 5 − 5 → alu_zero = 1. LUI in2 = 0x1234 → 0x12340000. NOR in1 = 0, in2 = 0xFFFF00F0 → 0xFFFFFF0F.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF → alu_hi = 0xFFFFFFFE, alu_out = 0x00000001, out_valid exactly 32 edges after accept. in_ready = 0 throughout the iteration.
- DIVU: 100 / 7 → alu_out = 14, alu_hi = 2 after 32 edges. Divide by zero with in1 = 0xDEADBEEF → alu_out = 0xFFFFFFFF, alu_hi = 0xDEADBEEF after 1 edge.
- Back-pressure: hold out_ready = 0 for 5 cycles after an ADD result → outputs stable and in_ready = 0. Then raise out_ready together with in_valid carrying an OR → the next result appears on the following edge with no bubble.
- Illegal opcode 9 → alu_err = 1 and alu_out = 0 after 1 edge. With ALU_SEQ_DIV_EN undefined, DIVU 100 / 7 → alu_err = 1 and alu_out = alu_hi = 0 after 1 edge.
